block_dispatcher: RTL and testbench

- Kernel-level block dispatcher that feeds every per-core `scheduler`.
- On a kernel launch it splits the total thread count into blocks of `THREADS_PER_BLOCK` threads. It hands each block to a free core with a one-cycle `core_start` pulse, plus that block's ID and thread count.
- It counts `core_done` completions and raises `done` once every block has retired.
- It sits between device control (launch/thread-count registers) and the array of compute cores.

---
 rtl/block_dispatcher.sv | 193 +++++++++++++++++++
 tb/tb_block_dispatcher.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_dispatcher.sv
// block_dispatcher: breaks a kernel launch into fixed-size thread blocks.
// Each block goes to the lowest-index free compute core. Completions are
// counted, and done is raised once every block has retired.
module block_dispatcher #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [7:0]                thread_count,
    input  logic [NUM_CORES-1:0]      core_done,
    output logic [NUM_CORES-1:0]      core_start,
    output logic [NUM_CORES-1:0][7:0] core_block_id,
    output logic [NUM_CORES-1:0][7:0] core_thread_count,
    output logic                      done
);

    localparam int         TPB_LOG2 = $clog2(THREADS_PER_BLOCK);
    localparam logic [7:0] TPB_MASK = 8'(THREADS_PER_BLOCK - 1);
    localparam logic [7:0] TPB_FULL = 8'(THREADS_PER_BLOCK);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } top_state_t;

    typedef enum logic [1:0] {
        C_FREE   = 2'd0,
        C_LAUNCH = 2'd1,
        C_BUSY   = 2'd2
    } core_state_t;

    top_state_t           state;
    top_state_t           state_next;
    core_state_t          core_state      [NUM_CORES];
    core_state_t          core_state_next [NUM_CORES];

    logic [7:0]           total_blocks;
    logic [7:0]           kernel_threads;
    logic [7:0]           blocks_dispatched;
    logic [7:0]           blocks_done;

    logic                 launch;
    logic                 finish;
    logic                 dispatch_any;
    logic [NUM_CORES-1:0] dispatch_sel;
    logic [NUM_CORES-1:0] retire;
    logic [7:0]           retire_count;
    logic                 last_block;
    logic [7:0]           partial_threads;
    logic [7:0]           block_threads;

    // Top-level next state: accept a launch in IDLE, finish once all blocks retired.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    launch     = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (blocks_done == total_blocks) begin
                    finish     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Pick the lowest-index free core while undispatched blocks remain (one per cycle).
    always_comb begin
        dispatch_sel = '0;
        dispatch_any = 1'b0;
        if ((state == S_RUN) && (blocks_dispatched < total_blocks)) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (!dispatch_any && (core_state[k] == C_FREE)) begin
                    dispatch_sel[k] = 1'b1;
                    dispatch_any    = 1'b1;
                end
            end
        end
    end

    // Thread count of the block about to go out: full, except for a partial tail block.
    always_comb begin
        last_block      = (blocks_dispatched == (total_blocks - 8'd1));
        partial_threads = kernel_threads & TPB_MASK;
        block_threads   = TPB_FULL;
        if (last_block && (partial_threads != 8'd0)) begin
            block_threads = partial_threads;
        end
    end

    // Per-core next state; core_done is only trusted in BUSY, since in LAUNCH it may be stale.
    always_comb begin
        retire = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            core_state_next[k] = core_state[k];
            case (core_state[k])
                C_FREE: begin
                    if (dispatch_sel[k]) begin
                        core_state_next[k] = C_LAUNCH;
                    end
                end
                C_LAUNCH: core_state_next[k] = C_BUSY;
                C_BUSY: begin
                    if (core_done[k]) begin
                        retire[k]          = 1'b1;
                        core_state_next[k] = C_FREE;
                    end
                end
                default: core_state_next[k] = C_FREE;
            endcase
        end
    end

    // Several cores may retire in the same cycle; all of them are counted.
    always_comb begin
        retire_count = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            retire_count = retire_count + 8'(retire[k]);
        end
    end

    // Top state register, kernel bookkeeping counters and the done level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            total_blocks      <= '0;
            kernel_threads    <= '0;
            blocks_dispatched <= '0;
            blocks_done       <= '0;
            done              <= 1'b0;
        end else begin
            state <= state_next;
            if (launch) begin
                // Round up with a 9-bit sum so that 253..255 threads do not wrap.
                total_blocks      <= 8'(({1'b0, thread_count} + 9'(THREADS_PER_BLOCK - 1)) >> TPB_LOG2);
                kernel_threads    <= thread_count;
                blocks_dispatched <= '0;
                blocks_done       <= '0;
                done              <= 1'b0;
            end else begin
                if (dispatch_any) begin
                    blocks_dispatched <= blocks_dispatched + 8'd1;
                end
                blocks_done <= blocks_done + retire_count;
                if (finish) begin
                    done <= 1'b1;
                end
            end
        end
    end

    // Per-core state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                core_state[k] <= C_FREE;
            end
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                core_state[k] <= core_state_next[k];
            end
        end
    end

    // Registered launch pulse; block ID and count hold until that core's next dispatch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_start        <= '0;
            core_block_id     <= '0;
            core_thread_count <= '0;
        end else begin
            core_start <= dispatch_sel;
            for (int k = 0; k < NUM_CORES; k++) begin
                if (dispatch_sel[k]) begin
                    core_block_id[k]     <= blocks_dispatched;
                    core_thread_count[k] <= block_threads;
                end
            end
        end
    end

endmodule

// File: tb/tb_block_dispatcher.sv
// tb_block_dispatcher: directed and randomized kernels against a block-level
// reference model; core stand-ins hold core_done through relaunch like the scheduler.
module tb_block_dispatcher;

    localparam int NUM_CORES = 2;
    localparam int TPB       = 4;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      start;
    logic [7:0]                thread_count;
    logic [NUM_CORES-1:0]      core_done;
    logic [NUM_CORES-1:0]      core_start;
    logic [NUM_CORES-1:0][7:0] core_block_id;
    logic [NUM_CORES-1:0][7:0] core_thread_count;
    logic                      done;

    int checks = 0;
    int errors = 0;

    // Reference model: kernel size, block progress, and what each core holds.
    int kernel_threads;
    int total;
    int next_block;
    int retired;
    bit occupied    [NUM_CORES];
    int edges_since [NUM_CORES];
    int exp_id      [NUM_CORES];
    int exp_cnt     [NUM_CORES];

    // Core stand-ins: latency after the stale cycle (0 = random 1..8).
    bit pend_clear [NUM_CORES];
    int remain     [NUM_CORES];
    int lat_cfg    [NUM_CORES];

    block_dispatcher #(
        .NUM_CORES         (NUM_CORES),
        .THREADS_PER_BLOCK (TPB)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .thread_count      (thread_count),
        .core_done         (core_done),
        .core_start        (core_start),
        .core_block_id     (core_block_id),
        .core_thread_count (core_thread_count),
        .done              (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Core behaviour: keep the old core_done one cycle past core_start, then clear, then finish.
    task automatic core_update();
        for (int k = 0; k < NUM_CORES; k++) begin
            if (core_start[k]) begin
                pend_clear[k] = 1'b1;
            end else if (pend_clear[k]) begin
                pend_clear[k] = 1'b0;
                core_done[k]  = 1'b0;
                remain[k]     = (lat_cfg[k] != 0) ? lat_cfg[k] : int'($urandom_range(1, 8));
            end else if (remain[k] > 0) begin
                remain[k]--;
                if (remain[k] == 0) core_done[k] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        core_update();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_core_start"}, 32'(core_start), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        for (int k = 0; k < NUM_CORES; k++) begin
            check($sformatf("%s_block_id[%0d]", tag, k), 32'(core_block_id[k]), 32'd0);
            check($sformatf("%s_thread_cnt[%0d]", tag, k), 32'(core_thread_count[k]), 32'd0);
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < NUM_CORES; k++) begin
            occupied[k]    = 1'b0;
            edges_since[k] = 0;
            exp_id[k]      = 0;
            exp_cnt[k]     = 0;
            pend_clear[k]  = 1'b0;
            remain[k]      = 0;
        end
        core_done  = '0;
        next_block = 0;
        retired    = 0;
        total      = 0;
    endtask

    // Launch a kernel; the model forgets thread_count right after it is sampled.
    task automatic launch(input int tc);
        start        = 1'b1;
        thread_count = 8'(tc);
        tick();
        start        = 1'b0;
        thread_count = 8'($urandom);
        kernel_threads = tc;
        total          = (tc + TPB - 1) / TPB;
        next_block     = 0;
        retired        = 0;
        check("launch_done_cleared", 32'(done), 32'd0);
        check("launch_no_core_start", 32'(core_start), 32'd0);
    endtask

    // Predict the coming edge from pre-edge state, pass it, then compare every output.
    task automatic cycle_step();
        logic [NUM_CORES-1:0] exp_start;
        bit                   picked;
        int                   left;
        exp_start = '0;
        picked    = 1'b0;
        if (next_block < total) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (!picked && !occupied[k]) begin
                    picked       = 1'b1;
                    exp_start[k] = 1'b1;
                    left         = kernel_threads - next_block * TPB;
                    exp_id[k]    = next_block;
                    exp_cnt[k]   = (left < TPB) ? left : TPB;
                end
            end
        end
        for (int k = 0; k < NUM_CORES; k++) begin
            if (occupied[k]) begin
                if ((edges_since[k] >= 1) && core_done[k]) begin
                    occupied[k] = 1'b0;
                    retired++;
                end else begin
                    edges_since[k]++;
                end
            end
        end
        for (int k = 0; k < NUM_CORES; k++) begin
            if (exp_start[k]) begin
                occupied[k]    = 1'b1;
                edges_since[k] = 0;
                next_block++;
            end
        end
        tick();
        check("core_start", 32'(core_start), 32'(exp_start));
        for (int k = 0; k < NUM_CORES; k++) begin
            check($sformatf("block_id[%0d]", k), 32'(core_block_id[k]), exp_id[k]);
            check($sformatf("thread_cnt[%0d]", k), 32'(core_thread_count[k]), exp_cnt[k]);
        end
        check("done_low_in_run", 32'(done), 32'd0);
    endtask

    // Run until every block is retired, then check done timing and hold.
    task automatic finish_kernel(input bit poke_start_in_done);
        int guard;
        guard = 0;
        while ((retired < total) && (guard < 2000)) begin
            cycle_step();
            guard++;
        end
        tick();
        check("done_rise", 32'(done), 32'd1);
        check("done_edge_no_core_start", 32'(core_start), 32'd0);
        if (poke_start_in_done) begin
            start        = 1'b1;
            thread_count = 8'd99;
        end
        tick();
        start = 1'b0;
        check("done_hold_idle", 32'(done), 32'd1);
        tick();
        check("done_still_held", 32'(done), 32'd1);
        check("idle_no_core_start", 32'(core_start), 32'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        thread_count = 8'd0;
        reset_model();
        for (int k = 0; k < NUM_CORES; k++) lat_cfg[k] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Two full blocks, fixed latency: core0 then core1 on consecutive cycles.
        lat_cfg[0] = 5;
        lat_cfg[1] = 5;
        launch(8);
        finish_kernel(1'b0);

        // Three blocks 4/4/2 with random latency; start poked while in DONE.
        lat_cfg[0] = 0;
        lat_cfg[1] = 0;
        launch(10);
        finish_kernel(1'b1);

        // Shortest latency: every relaunch sees a stale core_done for a cycle.
        lat_cfg[0] = 1;
        lat_cfg[1] = 1;
        launch(21);
        finish_kernel(1'b0);

        // Empty kernel: done without any dispatch.
        launch(0);
        finish_kernel(1'b0);

        // Simultaneous completions on both cores plus a start pulse during RUN.
        lat_cfg[0] = 5;
        lat_cfg[1] = 4;
        launch(8);
        cycle_step();
        cycle_step();
        start        = 1'b1;
        thread_count = 8'd200;
        cycle_step();
        start        = 1'b0;
        finish_kernel(1'b0);

        // Asynchronous reset with two blocks in flight, then a fresh kernel.
        lat_cfg[0] = 6;
        lat_cfg[1] = 6;
        launch(16);
        cycle_step();
        cycle_step();
        cycle_step();
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        reset_model();
        @(posedge clk);
        #1;
        check_all_zero("reset_held");
        reset_n = 1'b1;
        launch(16);
        finish_kernel(1'b0);

        // Largest kernel: 64 blocks, last block has 3 threads.
        lat_cfg[0] = 0;
        lat_cfg[1] = 0;
        launch(255);
        finish_kernel(1'b0);

        // Random kernel sizes and latencies.
        for (int r = 0; r < 4; r++) begin
            launch(int'($urandom_range(1, 40)));
            finish_kernel(r[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
